// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit control path.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_CAPTURE
    } rx_ctrl_state_t;

    localparam int unsigned BITS_PER_FRAME = 10;
    localparam int unsigned OVERSAMPLE     = 8;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned clog2_plus1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered head output, occupancy count and flush.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       bclkx8,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = clog2_plus1(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign rd_ptr_nx = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    // Storage array; a flush discards a same-cycle push.
    always_ff @(posedge bclkx8) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge bclkx8 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nx;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Head slot is being written this cycle when the FIFO is empty,
            // or when the last entry is popped while a new one arrives.
            if (do_push && (wr_ptr == rd_ptr_nx))
                rdata <= wdata;
            else
                rdata <= mem[rd_ptr_nx];
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: captures completed bytes into a FIFO, host read port,
// level / character-timeout / overflow interrupts.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned THRESH      = 4,
    parameter int unsigned TIMEOUT_CYC = 4 * BITS_PER_FRAME * OVERSAMPLE
) (
    input  logic                       bclkx8,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       rx_status,
    input  logic [7:0]                 rhr,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic                       irq_level,
    output logic                       irq_timeout,
    output logic                       irq
);

    localparam int unsigned LW = clog2_plus1(DEPTH);
    localparam int unsigned TW = clog2_plus1(TIMEOUT_CYC);

    rx_ctrl_state_t state;
    rx_ctrl_state_t state_nx;
    logic           rx_status_q;
    logic           fall;
    logic           capture;
    logic           full;
    logic           empty;
    logic           pop;
    logic           push;
    logic           drop;
    logic [TW-1:0]  to_cnt;
    logic           overflow_d;
    logic           irq_level_d;
    logic           irq_timeout_d;

    assign fall     = rx_status_q & ~rx_status;
    assign capture  = (state == RX_CAPTURE);
    assign rd_valid = ~empty;
    assign pop      = ~empty & rd_ready;
    assign push     = capture & en & (~full | pop);
    assign drop     = capture & en & full & ~pop;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .bclkx8 (bclkx8),
        .rst_n  (rst_n),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .wdata  (rhr),
        .rdata  (rd_data),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    // Next-state logic following the receiver busy flag.
    always_comb begin
        state_nx = state;
        case (state)
            RX_IDLE:    if (rx_status) state_nx = RX_RECV;
            RX_RECV:    if (fall) state_nx = RX_CAPTURE;
            RX_CAPTURE: state_nx = rx_status ? RX_RECV : RX_IDLE;
            default:    state_nx = RX_IDLE;
        endcase
    end

    // State register and busy-flag delay for fall detection.
    always_ff @(posedge bclkx8 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            rx_status_q <= 1'b0;
        end else begin
            state       <= state_nx;
            rx_status_q <= rx_status;
        end
    end

    // Saturating idle counter; only runs while data waits and no frame is in flight.
    always_ff @(posedge bclkx8 or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (push || pop || flush || (level == '0))
            to_cnt <= '0;
        else if ((state == RX_IDLE) && (to_cnt != TW'(TIMEOUT_CYC)))
            to_cnt <= to_cnt + 1'b1;
    end

    // Interrupt sources computed from current state, registered below.
    always_comb begin
        overflow_d    = drop | (overflow & ~ovf_clr);
        irq_level_d   = (level >= LW'(THRESH));
        irq_timeout_d = (to_cnt == TW'(TIMEOUT_CYC)) & (level != '0);
    end

    // Registered sticky overflow and interrupt outputs.
    always_ff @(posedge bclkx8 or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            irq_level   <= 1'b0;
            irq_timeout <= 1'b0;
            irq         <= 1'b0;
        end else begin
            overflow    <= overflow_d;
            irq_level   <= irq_level_d;
            irq_timeout <= irq_timeout_d;
            irq         <= irq_level_d | irq_timeout_d | overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scoreboard bench for uart_rx_ctrl (default parameters).
module tb_uart_rx_ctrl;

    logic       bclkx8 = 1'b0;
    logic       rst_n;
    logic       en;
    logic       flush;
    logic       rx_status;
    logic [7:0] rhr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] level;
    logic       overflow;
    logic       ovf_clr;
    logic       irq_level;
    logic       irq_timeout;
    logic       irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 bclkx8 = ~bclkx8;

    uart_rx_ctrl #(
        .DEPTH       (8),
        .THRESH      (4),
        .TIMEOUT_CYC (320)
    ) dut (
        .bclkx8      (bclkx8),
        .rst_n       (rst_n),
        .en          (en),
        .flush       (flush),
        .rx_status   (rx_status),
        .rhr         (rhr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .irq_level   (irq_level),
        .irq_timeout (irq_timeout),
        .irq         (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame: busy for 8 cycles, fall, byte on rhr during CAPTURE.
    // Returns at the negedge after the push edge.
    task automatic send_frame(input logic [7:0] b, input bit exp_push,
                              input bit pop_cap, input bit chk_lat);
        rx_status = 1'b1;
        repeat (8) @(negedge bclkx8);
        rx_status = 1'b0;
        @(negedge bclkx8);
        rhr = b;
        if (chk_lat)
            chk("no_fallthrough", 32'(rd_valid), 0);
        if (pop_cap) begin
            chk("cap_pop_valid", 32'(rd_valid), 1);
            if (exp_q.size() != 0)
                chk("cap_pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            rd_ready = 1'b1;
        end
        if (exp_push)
            exp_q.push_back(b);
        @(negedge bclkx8);
        rd_ready = 1'b0;
    endtask

    task automatic pop_one();
        int n;
        n = 0;
        while (!rd_valid && n < 20) begin
            @(negedge bclkx8);
            n++;
        end
        if (!rd_valid || exp_q.size() == 0) begin
            chk("pop_wait_valid", 32'(rd_valid && exp_q.size() != 0), 1);
        end else begin
            chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
            rd_ready = 1'b1;
            @(negedge bclkx8);
            rd_ready = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; rx_status = 1'b0;
        rhr = 8'h00; rd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge bclkx8);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_irq", 32'({irq, irq_level, irq_timeout}), 0);
        rst_n = 1'b1;
        @(negedge bclkx8);

        // First frame: visible exactly two cycles after the fall.
        send_frame(8'hA5, 1, 0, 1);
        chk("a5_valid", 32'(rd_valid), 1);
        chk("a5_data", 32'(rd_data), 32'(exp_q[0]));
        chk("a5_level", 32'(level), 1);
        chk("a5_irq", 32'(irq), 0);
        pop_one();
        chk("a5_drained", 32'(level), 0);

        // Level threshold.
        for (int i = 1; i <= 4; i++)
            send_frame(8'(i), 1, 0, 0);
        chk("thr_level", 32'(level), 4);
        chk("thr_irq_lvl_lag", 32'(irq_level), 0);
        @(negedge bclkx8);
        chk("thr_irq_lvl", 32'(irq_level), 1);
        chk("thr_irq", 32'(irq), 1);
        pop_one();
        @(negedge bclkx8);
        chk("thr_irq_lvl_clr", 32'(irq_level), 0);
        repeat (3) pop_one();

        // Overflow on a full FIFO.
        for (int i = 0; i < 8; i++)
            send_frame(8'h10 + 8'(i), 1, 0, 0);
        chk("full_level", 32'(level), 8);
        send_frame(8'hFF, 0, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(level), 8);
        chk("ovf_head", 32'(rd_data), 32'(exp_q[0]));
        chk("ovf_irq", 32'(irq), 1);
        ovf_clr = 1'b1;
        @(negedge bclkx8);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Full with a pop coinciding with CAPTURE: accepted, no overflow.
        send_frame(8'hEE, 1, 1, 0);
        chk("fullpop_ovf", 32'(overflow), 0);
        chk("fullpop_level", 32'(level), 8);
        repeat (8) pop_one();
        chk("fullpop_empty", 32'(rd_valid), 0);

        // No timeout with an empty FIFO.
        repeat (400) @(negedge bclkx8);
        chk("to_empty", 32'(irq_timeout), 0);

        // Character timeout.
        send_frame(8'h5A, 1, 0, 0);
        repeat (310) @(negedge bclkx8);
        chk("to_early", 32'(irq_timeout), 0);
        repeat (15) @(negedge bclkx8);
        chk("to_fire", 32'(irq_timeout), 1);
        chk("to_irq", 32'(irq), 1);
        pop_one();
        @(negedge bclkx8);
        chk("to_clr", 32'(irq_timeout), 0);
        repeat (400) @(negedge bclkx8);
        chk("to_empty2", 32'(irq_timeout), 0);

        // Capture disabled.
        en = 1'b0;
        send_frame(8'h77, 0, 0, 0);
        chk("dis_level", 32'(level), 0);
        en = 1'b1;

        // Flush with three bytes queued.
        for (int i = 0; i < 3; i++)
            send_frame(8'h30 + 8'(i), 1, 0, 0);
        chk("flush_pre", 32'(level), 3);
        flush = 1'b1;
        @(negedge bclkx8);
        flush = 1'b0;
        exp_q.delete();
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(rd_valid), 0);

        // Asynchronous reset mid-frame, with rx_status still busy afterwards.
        send_frame(8'h42, 1, 0, 0);
        rx_status = 1'b1;
        repeat (3) @(negedge bclkx8);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_valid", 32'(rd_valid), 0);
        chk("arst_data", 32'(rd_data), 0);
        exp_q.delete();
        @(negedge bclkx8);
        rst_n = 1'b1;
        repeat (3) @(negedge bclkx8);
        rx_status = 1'b0;
        @(negedge bclkx8);
        rhr = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge bclkx8);
        chk("arst_partial_valid", 32'(rd_valid), 1);
        pop_one();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the 8x-oversampled UART receiver. Tracks the receiver's busy/status output and captures each completed byte from its holding register into a local FIFO. Presents the bytes to the host over a valid/ready read port. Generates level, character-timeout and overflow interrupts. Sits between the receiver and the host/bus register block, in the bclkx8 domain.

Parameters:
DEPTH, 8, FIFO depth in bytes; power of two, 2..64.
THRESH, 4, irq_level asserts when level >= THRESH; range 1..DEPTH.
TIMEOUT_CYC, 320, idle bclkx8 cycles before irq_timeout (4 char times x 80 cycles).

Ports:
bclkx8  in  1  sole clock, 8x baud; same clock as the receiver.
rst_n  in  1  asynchronous active-low reset.
en  in  1  capture enable; 0 = completed frames are discarded.
flush  in  1  synchronous FIFO clear, single-cycle pulse.
rx_status  in  1  receiver busy: 1 during start/data phases, 0 in idle/stop.
rhr  in  8  receiver holding register; updates on the clock edge ending the stop cycle.
rd_data  out  8  FIFO head byte; valid only when rd_valid=1.
rd_valid  out  1  FIFO not empty.
rd_ready  in  1  host pop; pop occurs when rd_valid & rd_ready.
level  out  $clog2(DEPTH+1)  current FIFO occupancy.
overflow  out  1  sticky: a byte was dropped because the FIFO was full.
ovf_clr  in  1  clears overflow.
irq_level  out  1  level >= THRESH.
irq_timeout  out  1  data waiting and idle timeout expired.
irq  out  1  irq_level | irq_timeout | overflow.

Behaviour:
- Reset (rst_n=0, async): state IDLE; FIFO empty; rd_valid=0, rd_data=0, level=0; overflow=0; irq_level, irq_timeout, irq all 0; timeout counter 0; rx_status_q=0.
- rx_status is registered into rx_status_q every cycle. A fall is rx_status_q=1 & rx_status=0. On the cycle after a fall is detected, rhr holds the new byte.
- FSM, with states in the shared enum:
  - IDLE: rx_status=1 -> RECV.
  - RECV: fall -> CAPTURE.
  - CAPTURE, exactly one cycle:
    - en=1 and not full, or full with a pop this cycle: push rhr.
    - en=1 and full with no pop: drop the byte; overflow<=1.
    - en=0: discard silently.
    - Next state: IDLE, or RECV if rx_status=1.
- Latency: a pushed byte appears on rd_data with rd_valid=1 on the cycle after CAPTURE. Total is 2 cycles after the fall, with no fall-through.
- FIFO:
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is tracked separately, 0..DEPTH.
  - A push and a pop in the same cycle leave level unchanged.
  - A pop when empty is ignored.
  - rd_data is the registered head entry.
- flush: empties the FIFO (pointers and level to 0) next cycle and clears the timeout counter. A push in the same cycle is lost. flush does not touch overflow.
- overflow: set on a drop; cleared by ovf_clr. If a set and a clear occur in the same cycle, set wins.
- Timeout counter (saturating, width $clog2(TIMEOUT_CYC+1)):
  - Clears on any push, pop or flush, and whenever level=0.
  - Otherwise increments while the FSM is IDLE. It holds during RECV/CAPTURE, since a frame in progress is not idle.
  - irq_timeout = (counter == TIMEOUT_CYC) & level != 0.
- All irq outputs are registered, updating one cycle after the causing event.
- en deasserted mid-frame: the FSM still tracks the frame, and CAPTURE discards it.
- rx_status asserted out of reset: IDLE->RECV. A partial frame is captured normally once it completes.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_CAPTURE} rx_ctrl_state_t;
  - localparams for BITS_PER_FRAME=10 and OVERSAMPLE=8.
  - Helper function clog2_plus1.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH) handles push, pop, flush, level, full and empty. The transmit path will reuse it.
- The top level holds the FSM, edge detect, timeout counter and irq logic.

Test Plan:
- Reset, then one frame with rhr=0xA5 -> rd_valid=1 and rd_data=0xA5 two cycles after the fall. level=1, irq=0.
- Push 4 bytes (0x01..0x04) with rd_ready=0 -> irq_level=1 one cycle after the 4th push. Pop 1 -> irq_level=0; pops return 0x01 first, in order.
- Fill 8 bytes, then send a 9th frame 0xFF with rd_ready=0 -> overflow=1, level=8, head still the 1st byte. ovf_clr -> overflow=0.
- FIFO full, and the 9th CAPTURE coincides with rd_valid&rd_ready -> no overflow, level stays 8, 0xFF is at tail.
- One byte pushed, then idle for 320 cycles -> irq_timeout=1. A pop clears it next cycle. With level=0, no timeout ever fires.
- en=0 for one frame, flush with 3 bytes queued, and rst_n asserted mid-RECV -> no push; level=0 next cycle; all outputs at reset values asynchronously.
